// File: rtl/alu_issue_queue_pkg.sv
// Shared types and opcode constants for the ALU issue queue.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_NOTA  = 4'h4;
  localparam logic [3:0] OP_NOTB  = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_NAND  = 4'h9;
  localparam logic [3:0] OP_XNOR  = 4'hA;
  localparam logic [3:0] OP_NOR   = 4'hB;
  localparam logic [3:0] OP_PASSA = 4'hC;
  localparam logic [3:0] OP_PASSB = 4'hD;
  localparam logic [3:0] OP_SHLA  = 4'hE;
  localparam logic [3:0] OP_SHLB  = 4'hF;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        opcode;
  } instr_t;

  function automatic logic is_div_by_zero(input instr_t i);
    return (i.opcode == OP_DIV) && (i.b == '0);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Instruction, ALU and result handshake bundle; the queue sits on the slave side.
interface alu_issue_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            in_a;
  logic [DATA_W-1:0]            in_b;
  logic [3:0]                   in_opcode;
  logic [DATA_W-1:0]            alu_a;
  logic [DATA_W-1:0]            alu_b;
  logic [3:0]                   alu_opcode;
  logic [DATA_W-1:0]            alu_result;
  logic                         alu_carry;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_result;
  logic                         out_carry;
  logic                         out_err;
  logic [3:0]                   out_opcode;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, alu_result, alu_carry, out_ready,
    output in_ready, alu_a, alu_b, alu_opcode, out_valid, out_result,
           out_carry, out_err, out_opcode, count
  );

  modport master (
    output in_valid, in_a, in_b, in_opcode, alu_result, alu_carry, out_ready,
    input  in_ready, alu_a, alu_b, alu_opcode, out_valid, out_result,
           out_carry, out_err, out_opcode, count
  );
endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// Register-array FIFO with a combinational head read so the ALU sees the head immediately.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_do_push && (r_wr_ptr == PTR_W'(gi)))
          r_mem[gi] <= i_wdata;
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU instructions, presents the head to the external ALU and registers
// qualified results into a valid/ready output stage.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  instr_t               w_wr_instr;
  instr_t               w_head;
  logic [$bits(instr_t)-1:0] w_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_capture;

  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_result;
  logic                 r_out_carry;
  logic                 r_out_err;
  logic [3:0]           r_out_opcode;

  assign w_wr_instr = '{a: bus.in_a, b: bus.in_b, opcode: bus.in_opcode};
  assign w_head     = instr_t'(w_rdata);
  assign w_capture  = !w_empty && (!r_out_valid || bus.out_ready);

  sync_fifo #(
    .WIDTH ($bits(instr_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_pop   (w_capture),
    .i_wdata (w_wr_instr),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Stale FIFO contents must never reach the ALU when the queue is empty.
  assign bus.alu_a      = w_empty ? '0 : w_head.a;
  assign bus.alu_b      = w_empty ? '0 : w_head.b;
  assign bus.alu_opcode = w_empty ? '0 : w_head.opcode;
  assign bus.in_ready   = !w_full;
  assign bus.count      = w_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_opcode <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= w_head.opcode;
      // The ALU's divide output is undefined for b == 0, so it is overridden here.
      if (is_div_by_zero(w_head)) begin
        r_out_result <= '1;
        r_out_err    <= 1'b1;
      end else begin
        r_out_result <= bus.alu_result;
        r_out_err    <= 1'b0;
      end
      r_out_carry  <= (w_head.opcode == OP_ADD) ? bus.alu_carry : 1'b0;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_carry  = r_out_carry;
  assign bus.out_err    = r_out_err;
  assign bus.out_opcode = r_out_opcode;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomised scoreboard bench for alu_issue_queue with a behavioural ALU stand-in.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] result;
    logic       carry;
    logic       err;
    logic [3:0] op;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    rx_count = 0;
  bit    stream_mode = 1'b0;
  logic [15:0] w_prod;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(DEPTH)) bus();

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ALU stand-in: carry is deliberately noisy on non-ADD ops, and DIV by 0 gives junk.
  always_comb begin
    bus.alu_result = '0;
    bus.alu_carry  = 1'b0;
    w_prod = 16'(bus.alu_a) * 16'(bus.alu_b);
    case (bus.alu_opcode)
      OP_ADD:   {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB:   begin bus.alu_result = bus.alu_a - bus.alu_b; bus.alu_carry = bus.alu_a < bus.alu_b; end
      OP_MUL:   begin bus.alu_result = w_prod[7:0]; bus.alu_carry = |w_prod[15:8]; end
      OP_DIV:   begin
                  bus.alu_carry  = 1'b1;
                  bus.alu_result = (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : 8'hA5;
                end
      OP_NOTA:  begin bus.alu_result = ~bus.alu_a; bus.alu_carry = 1'b1; end
      OP_NOTB:  begin bus.alu_result = ~bus.alu_b; bus.alu_carry = 1'b1; end
      OP_AND:   begin bus.alu_result = bus.alu_a & bus.alu_b; bus.alu_carry = 1'b1; end
      OP_XOR:   begin bus.alu_result = bus.alu_a ^ bus.alu_b; bus.alu_carry = 1'b1; end
      OP_OR:    begin bus.alu_result = bus.alu_a | bus.alu_b; bus.alu_carry = 1'b1; end
      OP_NAND:  begin bus.alu_result = ~(bus.alu_a & bus.alu_b); bus.alu_carry = 1'b1; end
      OP_XNOR:  begin bus.alu_result = ~(bus.alu_a ^ bus.alu_b); bus.alu_carry = 1'b1; end
      OP_NOR:   begin bus.alu_result = ~(bus.alu_a | bus.alu_b); bus.alu_carry = 1'b1; end
      OP_PASSA: begin bus.alu_result = bus.alu_a; bus.alu_carry = 1'b1; end
      OP_PASSB: begin bus.alu_result = bus.alu_b; bus.alu_carry = 1'b1; end
      OP_SHLA:  {bus.alu_carry, bus.alu_result} = {bus.alu_a, 1'b0};
      OP_SHLB:  {bus.alu_carry, bus.alu_result} = {bus.alu_b, 1'b0};
      default:  bus.alu_result = '0;
    endcase
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ia = int'(a);
    int ib = int'(b);
    int r = 0;
    exp_t e;
    e.carry = 1'b0;
    e.err   = 1'b0;
    e.op    = op;
    case (op)
      OP_ADD:   begin r = ia + ib; e.carry = (r > 255); end
      OP_SUB:   r = ia - ib + 256;
      OP_MUL:   r = ia * ib;
      OP_DIV:   if (ib == 0) begin r = 255; e.err = 1'b1; end else r = ia / ib;
      OP_NOTA:  r = 255 - ia;
      OP_NOTB:  r = 255 - ib;
      OP_AND:   r = ia & ib;
      OP_XOR:   r = ia ^ ib;
      OP_OR:    r = ia | ib;
      OP_NAND:  r = 255 - (ia & ib);
      OP_XNOR:  r = 255 - (ia ^ ib);
      OP_NOR:   r = 255 - (ia | ib);
      OP_PASSA: r = ia;
      OP_PASSB: r = ib;
      OP_SHLA:  r = ia * 2;
      OP_SHLB:  r = ib * 2;
      default:  r = 0;
    endcase
    e.result = 8'(r % 256);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Call between a falling edge and the next rising edge; returns just after a falling edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    for (int t = 0; t < 200 && !done; t++) begin
      if (bus.in_ready) begin
        exp_q.push_back(model(a, b, op));
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && stream_mode) check("stream_count_le1", int'(bus.count <= 1), 1);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result actual=%02h required=none", bus.out_result);
        end else begin
          e = exp_q.pop_front();
          rx_count++;
          if (bus.out_result !== e.result || bus.out_carry !== e.carry ||
              bus.out_err !== e.err || bus.out_opcode !== e.op) begin
            failures++;
            $display("FAIL result op=%h actual=%02h/c%b/e%b/op%h required=%02h/c%b/e%b/op%h",
                     e.op, bus.out_result, bus.out_carry, bus.out_err, bus.out_opcode,
                     e.result, e.carry, e.err, e.op);
          end else begin
            $display("txn op=%h result=%02h carry=%b err=%b ok",
                     e.op, bus.out_result, bus.out_carry, bus.out_err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rx0;
    time t0;
    logic [7:0] ra, rb;
    logic [3:0] rop;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_out_regs", {bus.out_result, bus.out_carry, bus.out_err, bus.out_opcode}, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_alu_drive", {bus.alu_a, bus.alu_b, bus.alu_opcode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);

    // Single ADD with latency check.
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(8'd200, 8'd100, OP_ADD);
    check("lat_pre_valid", bus.out_valid, 0);
    check("lat_pre_count", bus.count, 1);
    @(negedge clk);
    #2;
    check("lat_n1_valid", bus.out_valid, 1);
    check("add_result", bus.out_result, 44);
    check("add_carry", bus.out_carry, 1);
    drain();

    // Backpressure fills the queue.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'd9, 8'd4, OP_SUB);
    send(8'hF0, 8'h3C, OP_AND);
    send(8'h5A, 8'h0F, OP_XOR);
    send(8'h12, 8'h21, OP_OR);
    send(8'hFF, 8'h0F, OP_NAND);
    check("bp_count", bus.count, 4);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_held_result", bus.out_result, 5);
    bus.out_ready = 1'b1;
    drain();
    check("bp_drained_count", bus.count, 0);

    // Divide-by-zero override then a normal divide.
    @(negedge clk);
    send(8'd10, 8'd0, OP_DIV);
    @(negedge clk);
    #2;
    check("div0_result", bus.out_result, 255);
    check("div0_err", bus.out_err, 1);
    check("div0_carry", bus.out_carry, 0);
    send(8'd10, 8'd3, OP_DIV);
    drain();

    // Carry is suppressed for non-ADD opcodes.
    @(negedge clk);
    send(8'h80, 8'h80, OP_SHLA);
    @(negedge clk);
    #2;
    check("shla_result", bus.out_result, 0);
    check("shla_carry", bus.out_carry, 0);
    drain();

    // Back-to-back random stream.
    @(negedge clk);
    stream_mode = 1'b1;
    rx0 = rx_count;
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      send(ra, rb, rop);
    end
    check("stream_cycles", int'(($time - t0) / 10), 16);
    drain();
    stream_mode = 1'b0;
    check("stream_rx", rx_count - rx0, 16);

    // Reset mid-stream discards queued and held results.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'd1, 8'd1, OP_ADD);
    send(8'd2, 8'd2, OP_MUL);
    send(8'd3, 8'd3, OP_XOR);
    send(8'd4, 8'd4, OP_OR);
    check("mid_count", bus.count, 3);
    check("mid_out_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_result", bus.out_result, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", bus.in_ready, 1);
    check("mid_rel_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send(8'd7, 8'd9, OP_ADD);
    drain();
    check("final_count", bus.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
